// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU types and sizes used by the divider
package cpu_pkg;

    localparam int XLEN      = 32;
    localparam int DIV_CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

endpackage

// File: rtl/seq_divider_div_step.sv
// rtl/seq_divider_div_step.sv - one restoring shift/trial-subtract iteration
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           q_bit;

    // Shift the next dividend bit into the partial remainder and keep the
    // subtraction only when it does not go negative (bit WIDTH is the sign).
    always_comb begin
        shifted  = {1'b0, rem[WIDTH-1:0]} << 1;
        shifted[0] = quo[WIDTH-1];
        diff     = shifted - {1'b0, dvs};
        q_bit    = ~diff[WIDTH];
        rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_next = {quo[WIDTH-2:0], q_bit};
    end

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle signed/unsigned restoring divider
module seq_divider
    import cpu_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             div_zero
);

    localparam logic [DIV_CNT_W-1:0] LAST_ITER = DIV_CNT_W'(WIDTH - 1);

    div_state_t           state;
    logic [DIV_CNT_W-1:0] cnt;
    logic [WIDTH-1:0]     rem;
    logic [WIDTH-1:0]     quo;
    logic [WIDTH-1:0]     dvs;
    logic                 neg_q;
    logic                 neg_r;
    logic                 dz;
    logic [WIDTH-1:0]     rem_next;
    logic [WIDTH-1:0]     quo_next;

    // Magnitude of an operand; the most negative value maps onto itself,
    // which is exactly its unsigned magnitude.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic sgn);
        return (sgn && x[WIDTH-1]) ? (~x + 1'b1) : x;
    endfunction

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .quo      (quo),
        .dvs      (dvs),
        .rem_next (rem_next),
        .quo_next (quo_next)
    );

    // Control FSM with registered outputs; iterations run on magnitudes and
    // the signs are reapplied in FIX.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= IDLE;
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            dvs      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            dz       <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            q        <= '0;
            r        <= '0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        quo   <= magnitude(dividend, is_signed);
                        dvs   <= magnitude(divisor, is_signed);
                        rem   <= '0;
                        cnt   <= '0;
                        neg_q <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        neg_r <= is_signed & dividend[WIDTH-1];
                        dz    <= (divisor == '0);
                        busy  <= 1'b1;
                        state <= CALC;
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    rem <= rem_next;
                    quo <= quo_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_ITER) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    // A zero divisor leaves the dividend magnitude in rem, so
                    // reapplying its sign restores the original dividend.
                    q        <= dz ? '1 : (neg_q ? (~quo + 1'b1) : quo);
                    r        <= neg_r ? (~rem + 1'b1) : rem;
                    div_zero <= dz;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= DONE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the operand and result width in bits.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rstn, input, 1, the reset: synchronous and active-low.
REQ-004 SHALL have port start, input, 1, request to begin a division.
REQ-005 SHALL have port is_signed, input, 1; 1 selects DIV semantics, 0 selects DIVU semantics.
REQ-006 SHALL have port dividend, input, WIDTH, the numerator.
REQ-007 SHALL have port divisor, input, WIDTH, the denominator.
REQ-008 SHALL have port busy, output, 1, high while a division is in progress.
REQ-009 SHALL have port done, output, 1, a one-cycle pulse when the result is valid.
REQ-010 SHALL have port q, output, WIDTH, the quotient, feeding the LO-select mux.
REQ-011 SHALL have port r, output, WIDTH, the remainder, feeding the HI-select mux.
REQ-012 SHALL have port div_zero, output, 1, high with done when divisor was 0.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, FIX and DONE.
REQ-014 SHALL accept start only in IDLE or DONE.
- At accepting edge N: capture operand magnitudes and sign flags, clear the 6-bit iteration counter, go to CALC.
REQ-015 SHALL ignore start in CALC and FIX; captured operands are not disturbed.
REQ-016 SHALL perform one restoring shift-subtract iteration per CALC cycle (edges N+1..N+32), then go to FIX.
REQ-017 SHALL apply sign correction in FIX at edge N+33, load q/r, then go to DONE.
- Quotient is negated iff is_signed and the operand signs differ.
- Remainder takes the sign of the dividend.
REQ-018 SHALL drive done=1 for exactly the cycle after edge N+33, then return to IDLE at edge N+34 unless start is re-accepted.
REQ-019 SHALL drive busy=1 in CALC and FIX only; busy=0 in IDLE and DONE.
REQ-020 SHALL hold q, r and div_zero stable from done until the next FIX load.
REQ-021 SHALL handle divisor==0 with the same latency: q=all-ones, r=dividend, div_zero=1.
REQ-022 SHALL return signed 0x80000000/0xFFFFFFFF as q=0x80000000, r=0, with no trap or flag.
REQ-023 SHALL compute all arithmetic at WIDTH+1 bits internally; the partial remainder never overflows.

Reset
REQ-024 SHALL, with rstn=0 at a clock edge, go to IDLE and zero the counter and outputs: busy=0, done=0, q=0, r=0, div_zero=0.
REQ-025 SHALL, when reset occurs mid-operation, abandon the division with no done pulse; the next start after rstn=1 proceeds normally.

Structure
REQ-026 SHALL take from the shared package cpu_pkg: the FSM state enum, the default WIDTH, and the iteration-counter width.
REQ-027 SHALL place one restoring iteration (shift, trial subtract, quotient bit) in a combinational sub-module div_step, instantiated once.

Verification
REQ-028 Unsigned 100/7, start at edge N -> busy during N+1..N+33, done only in cycle after N+33, q=14, r=2.
REQ-029 Signed 0xFFFFFFF9/2 -> q=0xFFFFFFFD, r=0xFFFFFFFF; unsigned same operands -> q=0x7FFFFFFC, r=1.
REQ-030 Signed 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0; unsigned same -> q=0, r=0x80000000.
REQ-031 5/0 in both modes -> q=0xFFFFFFFF, r=5, div_zero=1; next 9/3 -> q=3, r=0, div_zero=0.
REQ-032 start with new operands at iteration 10 -> ignored, original result returned; start during DONE -> accepted, back-to-back done 34 cycles apart.
REQ-033 rstn=0 at iteration 10 -> next cycle busy=0, q=r=0, and no done is ever seen for that division.
